// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx transmitter between NUM_REQ byte producers.
// Each frame goes to one requester. Its byte is latched, and uart_tx is started and
// held until it reports busy. The arbiter then waits for done, and an idle gap follows.
// A watchdog aborts any frame that stays in launch/wait for too long.
// Optional feature macro: UART_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority (lowest active index wins), no round-robin pointer
//   undefined -> round-robin arbitration (default)
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_en,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int GW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    logic [1:0]     state;
    logic [TW-1:0]  to_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [IDW-1:0] winner;

`ifdef UART_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest valid index is the last one written.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) winner = IDW'(i);
        end
    end
`else
    logic [IDW-1:0] rr_ptr;

    // Round-robin: the first valid requester after the last winner, wrapping around.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    // The pointer remembers the last winner. Its reset value makes requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IDW'(NUM_REQ - 1);
        end else if (state == S_IDLE && |req_valid) begin
            rr_ptr <= winner;
        end
    end
`endif

    // Frame sequencer: grant, launch until busy, wait for done or watchdog, then idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            req_ready   <= '0;
            tx_en       <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            active      <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ready   <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        tx_data   <= req_data[8*winner +: 8];
                        grant_id  <= winner;
                        req_ready <= NUM_REQ'(1) << winner;
                        tx_start  <= 1'b1;
                        tx_en     <= 1'b1;
                        active    <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        tx_start    <= 1'b0;
                        tx_en       <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (tx_busy) begin
                            tx_start <= 1'b0;
                            tx_en    <= 1'b0;
                            state    <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        frame_done <= 1'b1;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        tx_start    <= 1'b0;
                        tx_en       <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (GAP_CYCLES == 0 || gap_cnt == GAP_LAST) begin
                        active <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench for uart_tx_arbiter.
// The bench plays the role of uart_tx (busy/done) and of the requesters. Expected
// grants, bytes, pulses and timings come from a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TO  = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_en;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;
    logic [1:0]     grant_id;
    logic           active;
    logic           frame_done;
    logic           timeout_err;

    int checks   = 0;
    int failures = 0;
    int model_ptr;

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_en(tx_en),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .active(active),
        .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [8*N-1:0] d,
                                 input logic busy, input logic done);
        req_valid = v;
        req_data  = d;
        tx_busy   = busy;
        tx_done   = done;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, req_ready, 0);
        checkOutput({tag, "_en"}, tx_en, 0);
        checkOutput({tag, "_start"}, tx_start, 0);
        checkOutput({tag, "_data"}, tx_data, 0);
        checkOutput({tag, "_grant"}, grant_id, 0);
        checkOutput({tag, "_active"}, active, 0);
        checkOutput({tag, "_fdone"}, frame_done, 0);
        checkOutput({tag, "_tmo"}, timeout_err, 0);
    endtask

    // Reference arbitration rule
    function automatic int pickWinner(input logic [N-1:0] v);
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) if (v[(model_ptr + k) % N]) return (model_ptr + k) % N;
`endif
        return 0;
    endfunction

    // mode 0: normal frame, 1: busy never rises, 2: busy rises but done never comes
    task automatic runFrame(input logic [N-1:0] v, input logic [8*N-1:0] d, input int mode,
                            input int busy_delay, input int done_delay,
                            input bit spurious, input bit done_with_busy);
        int           w;
        logic [7:0]   exp_data;
        logic [N-1:0] exp_ready;
        logic [N-1:0] gap_v;
        w         = pickWinner(v);
        exp_data  = d[8*w +: 8];
        exp_ready = '0;
        exp_ready[w] = 1'b1;

        applyStimulus(v, d, 1'b0, spurious);
        tick();
        checkOutput("grant_ready", req_ready, exp_ready);
        checkOutput("grant_id", grant_id, w);
        checkOutput("grant_data", tx_data, exp_data);
        checkOutput("grant_start", tx_start, 1);
        checkOutput("grant_en", tx_en, 1);
        checkOutput("grant_active", active, 1);
        model_ptr = w;

        if (mode == 0) begin
            for (int i = 0; i < busy_delay; i++) begin
                applyStimulus(v, d, 1'b0, spurious && i == 0);
                tick();
                checkOutput("launch_start", tx_start, 1);
                checkOutput("launch_ready", req_ready, 0);
                checkOutput("launch_fdone", frame_done, 0);
            end
            applyStimulus(v, d, 1'b1, 1'b0);
            tick();
            checkOutput("busy_start", tx_start, 0);
            checkOutput("busy_en", tx_en, 0);
            checkOutput("busy_fdone", frame_done, 0);
            checkOutput("busy_active", active, 1);
            for (int i = 0; i < done_delay; i++) begin
                applyStimulus(v, d, 1'b1, 1'b0);
                tick();
                checkOutput("wait_fdone", frame_done, 0);
                checkOutput("wait_active", active, 1);
            end
            applyStimulus(v, d, done_with_busy, 1'b1);
            tick();
            checkOutput("done_fdone", frame_done, 1);
            checkOutput("done_tmo", timeout_err, 0);
            checkOutput("done_active", active, 1);
        end else begin
            for (int k = 1; k < TO; k++) begin
                applyStimulus(v, d, (mode == 2 && k > busy_delay), 1'b0);
                tick();
                checkOutput("wd_tmo", timeout_err, 0);
                checkOutput("wd_fdone", frame_done, 0);
                checkOutput("wd_start", tx_start, !(mode == 2 && k > busy_delay));
            end
            applyStimulus(v, d, (mode == 2), 1'b0);
            tick();
            checkOutput("tmo_pulse", timeout_err, 1);
            checkOutput("tmo_fdone", frame_done, 0);
            checkOutput("tmo_start", tx_start, 0);
            checkOutput("tmo_en", tx_en, 0);
            checkOutput("tmo_active", active, 1);
        end

        for (int g = 0; g < GAP; g++) begin
            gap_v = N'($urandom_range(1, (1 << N) - 1));
            applyStimulus(gap_v, d, 1'b0, 1'b0);
            tick();
            checkOutput("gap_active", active, (g + 1 < GAP));
            checkOutput("gap_ready", req_ready, 0);
            checkOutput("gap_fdone", frame_done, 0);
            checkOutput("gap_tmo", timeout_err, 0);
        end
        checkOutput("hold_data", tx_data, exp_data);
        checkOutput("hold_grant", grant_id, w);
    endtask

    task automatic idlePause(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, $urandom(), 1'b0, 1'(($urandom_range(0, 1))));
            tick();
            checkOutput("idle_active", active, 0);
            checkOutput("idle_ready", req_ready, 0);
            checkOutput("idle_fdone", frame_done, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int mode;
        int bd;
        rst_n = 1'b0;
        applyStimulus('0, '0, 1'b0, 1'b0);
        model_ptr = N - 1;
        tick();
        tick();
        checkResetState("reset");
        rst_n = 1'b1;
        tick();

        // Round-robin with all requesters held valid
        for (int f = 0; f < 5; f++) runFrame(4'b1111, 32'h44332211, 0, 1, 3, 1'b0, 1'b0);

        // Single requester 2 carrying A5, with a spurious done in idle and launch
        runFrame(4'b0100, 32'h00A50000, 0, 2, 4, 1'b1, 1'b1);
        idlePause(3);

        // Watchdog: busy stuck low, then done never arriving
        runFrame(4'b0011, $urandom(), 1, 0, 0, 1'b0, 1'b0);
        runFrame(4'b0011, $urandom(), 2, 3, 0, 1'b0, 1'b0);

`ifdef UART_ARB_FIXED_PRIO_EN
        for (int f = 0; f < 3; f++) runFrame(4'b1010, $urandom(), 0, 1, 2, 1'b0, 1'b0);
`endif

        // Reset asserted in the middle of a frame's wait-for-done phase
        runFrame(4'b0110, $urandom(), 0, 0, 1, 1'b0, 1'b0);
        applyStimulus(4'b0110, $urandom(), 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0110, req_data, 1'b1, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1 checkResetState("rst_mid");
        tick();
        rst_n = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        model_ptr = N - 1;
        tick();
        runFrame(4'b1111, $urandom(), 0, 1, 2, 1'b0, 1'b0);

        // Randomized traffic
        for (int f = 0; f < 30; f++) begin
            mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            bd   = int'($urandom_range(0, 4));
            runFrame(N'($urandom_range(1, (1 << N) - 1)), $urandom(), mode, bd,
                     int'($urandom_range(0, 10)), (bd > 0) && ($urandom_range(0, 1) == 1),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idlePause(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
